// File: rtl/uart_rx_capture.sv
// uart_rx_capture
//   UART receiver (8N1, LSB first) that converts a serial console stream into
//   a byte stream behind a first-word fall-through FIFO with valid/ready.
//   Stop-bit errors and FIFO overflow are reported as sticky flags.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   i_rx         serial line, idles high, asynchronous to clk
//   o_data       byte at the FIFO head (0 while empty)
//   o_valid      FIFO not empty
//   i_ready      consumer takes o_data when o_valid & i_ready
//   o_count      FIFO occupancy, 0..FIFO_DEPTH
//   o_frame_err  sticky: stop bit sampled low
//   o_overflow   sticky: byte dropped because the FIFO was full
//   i_clr        one-cycle pulse clearing both sticky flags
//
// FSM states
//   state     | meaning
//   IDLE      | line idle, waiting for a falling edge on rx_s
//   START     | half-bit wait, then confirm the start bit is still low
//   DATA      | sample 8 data bits at mid-bit, LSB first
//   STOP      | sample stop bit; high pushes the byte, low flags framing error
//   WAIT_HIGH | after a bad stop, hold off until the line returns high
module uart_rx_capture #(
    parameter int CLK_DIV    = 217,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          i_rx,
    output logic [7:0]                    o_data,
    output logic                          o_valid,
    input  logic                          i_ready,
    output logic [$clog2(FIFO_DEPTH):0]   o_count,
    output logic                          o_frame_err,
    output logic                          o_overflow,
    input  logic                          i_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [15:0]   FULL_BIT = 16'(CLK_DIV - 1);
    localparam logic [15:0]   HALF_BIT = 16'(CLK_DIV / 2 - 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    // Synchronizer and edge detect; preset high so reset looks like idle line
    logic sync1_q, rx_s_q, rx_prev_q;
    logic rx_fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= i_rx;
            rx_s_q    <= sync1_q;
            rx_prev_q <= rx_s_q;
        end
    end

    assign rx_fall = rx_prev_q & ~rx_s_q;

    // Receive FSM
    state_t      state_q;
    logic [15:0] timer_q;
    logic [2:0]  bit_idx_q;
    logic [7:0]  shift_q;
    logic        stop_sample;

    assign stop_sample = (state_q == STOP) && (timer_q == 16'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_fall) begin
                        timer_q <= HALF_BIT;
                        state_q <= START;
                    end
                end
                START: begin
                    if (timer_q == 16'd0) begin
                        if (!rx_s_q) begin
                            timer_q   <= FULL_BIT;
                            bit_idx_q <= '0;
                            state_q   <= DATA;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                DATA: begin
                    if (timer_q == 16'd0) begin
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        timer_q <= FULL_BIT;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                STOP: begin
                    if (timer_q == 16'd0) begin
                        state_q <= rx_s_q ? IDLE : WAIT_HIGH;
                    end else begin
                        timer_q <= timer_q - 16'd1;
                    end
                end
                WAIT_HIGH: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output FIFO
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          frame_err_q, overflow_q;
    logic          push_req, pop, full, wr_en;

    assign push_req = stop_sample & rx_s_q;
    assign pop      = o_valid & i_ready;
    assign full     = (count_q == DEPTH_C);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign wr_en    = push_req & (~full | pop);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= shift_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_err_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (wr_en && !pop) begin
                count_q <= count_q + CW'(1);
            end else if (!wr_en && pop) begin
                count_q <= count_q - CW'(1);
            end
            // Set has priority over clear
            if (stop_sample && !rx_s_q) begin
                frame_err_q <= 1'b1;
            end else if (i_clr) begin
                frame_err_q <= 1'b0;
            end
            if (push_req && full && !pop) begin
                overflow_q <= 1'b1;
            end else if (i_clr) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign o_valid     = (count_q != '0);
    assign o_data      = o_valid ? mem_q[rd_ptr_q] : 8'h00;
    assign o_count     = count_q;
    assign o_frame_err = frame_err_q;
    assign o_overflow  = overflow_q;

endmodule

// File: tb/tb_uart_rx_capture.sv
module tb_uart_rx_capture;

    localparam int CLK_DIV    = 8;
    localparam int FIFO_DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       i_rx;
    logic [7:0] o_data;
    logic       o_valid;
    logic       i_ready;
    logic [4:0] o_count;
    logic       o_frame_err;
    logic       o_overflow;
    logic       i_clr;

    uart_rx_capture #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rx        (i_rx),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_count     (o_count),
        .o_frame_err (o_frame_err),
        .o_overflow  (o_overflow),
        .i_clr       (i_clr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Consumer monitor: records every accepted byte and the cycle it was seen
    logic [7:0] rxq[$];
    int         pop_cyc[$];
    int         valid_cycles = 0;

    always begin
        @(negedge clk);
        #1;
        if (rst_n && o_valid) valid_cycles++;
        if (rst_n && o_valid && i_ready) begin
            rxq.push_back(o_data);
            pop_cyc.push_back(cyc);
        end
    end

    int start_cyc;

    // One frame, driven per clock: start, 8 data LSB first, stop_low extra
    // low bit-times in the stop position, then one high stop bit.
    // rdy_c / rst_c (cycle offsets, -1 = unused) pulse i_ready / rst_n.
    task automatic send_frame(input logic [7:0] b, input int stop_low,
                              input int rdy_c, input int rst_c);
        int   nbits;
        int   bi;
        logic v;
        nbits = 10 + stop_low;
        for (int c = 0; c < nbits * CLK_DIV; c++) begin
            @(negedge clk);
            if (c == 0) start_cyc = cyc;
            bi = c / CLK_DIV;
            if (bi == 0)                 v = 1'b0;
            else if (bi <= 8)            v = b[bi-1];
            else if (bi < 9 + stop_low)  v = 1'b0;
            else                         v = 1'b1;
            i_rx = v;
            if (rdy_c >= 0) begin
                if (c == rdy_c)          i_ready = 1'b1;
                else if (c == rdy_c + 1) i_ready = 1'b0;
            end
            if (rst_c >= 0) begin
                if (c == rst_c) begin
                    rst_n = 1'b0;
                end else if (c == rst_c + 1) begin
                    rst_n = 1'b1;
                    chk("rst_mid_valid", o_valid, 0);
                    chk("rst_mid_count", o_count, 0);
                    chk("rst_mid_data", o_data, 8'h00);
                    chk("rst_mid_ferr", o_frame_err, 0);
                    chk("rst_mid_ovf", o_overflow, 0);
                end
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #2;
    endtask

    task automatic drain();
        i_ready = 1'b1;
        repeat (40) @(negedge clk);
        i_ready = 1'b0;
        #2;
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        i_clr = 1'b1;
        @(negedge clk);
        i_clr = 1'b0;
    endtask

    int vc0;

    initial begin
        rst_n   = 1'b0;
        i_rx    = 1'b1;
        i_ready = 1'b0;
        i_clr   = 1'b0;
        idle(3);
        chk("reset_valid", o_valid, 0);
        chk("reset_count", o_count, 0);
        chk("reset_data", o_data, 8'h00);
        chk("reset_ferr", o_frame_err, 0);
        chk("reset_ovf", o_overflow, 0);
        rst_n = 1'b1;
        idle(CLK_DIV);

        // 1: single byte, consumer always ready
        i_ready = 1'b1;
        vc0 = valid_cycles;
        send_frame(8'h55, 0, -1, -1);
        settle();
        chk("t1_nbytes", rxq.size(), 1);
        chk("t1_data", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h55);
        chk("t1_valid_cycles", valid_cycles - vc0, 1);
        // start drive to first visible valid: 79 cycles, window 9..11 bits
        chk("t1_latency_ok",
            (pop_cyc.size() > 0) && (pop_cyc[0] - start_cyc >= 9 * CLK_DIV)
                                 && (pop_cyc[0] - start_cyc <= 11 * CLK_DIV), 1);
        chk("t1_ferr", o_frame_err, 0);
        i_ready = 1'b0;
        idle(CLK_DIV);

        // 2: fill to full, then overflow
        rxq.delete();
        for (int i = 1; i <= 16; i++) begin
            send_frame(8'(i), 0, -1, -1);
        end
        chk("t2_count_full", o_count, 16);
        chk("t2_ovf_clear", o_overflow, 0);
        chk("t2_head_held", o_data, 8'h01);
        send_frame(8'h11, 0, -1, -1);
        chk("t2_ovf_set", o_overflow, 1);
        chk("t2_count_still", o_count, 16);
        chk("t2_head_after_drop", o_data, 8'h01);
        drain();
        chk("t2_drain_n", rxq.size(), 16);
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_data", (i < rxq.size()) ? rxq[i] : 8'hxx, 8'(i + 1));
        end
        chk("t2_count_empty", o_count, 0);
        pulse_clr();
        #1;
        chk("t2_ovf_cleared", o_overflow, 0);
        idle(CLK_DIV);

        // 3: push into a full FIFO while popping in the same cycle
        rxq.delete();
        for (int i = 0; i < 16; i++) begin
            send_frame(8'h31 + 8'(i), 0, -1, -1);
        end
        send_frame(8'h22, 0, 78, -1);
        chk("t3_count", o_count, 16);
        chk("t3_ovf", o_overflow, 0);
        drain();
        chk("t3_drain_n", rxq.size(), 17);
        for (int i = 0; i < 16; i++) begin
            chk("t3_drain_data", (i < rxq.size()) ? rxq[i] : 8'hxx, 8'h31 + 8'(i));
        end
        chk("t3_last", (rxq.size() > 0) ? rxq[$] : 8'hxx, 8'h22);
        idle(CLK_DIV);

        // 4: stop bit held low for 3 bit-times
        rxq.delete();
        i_ready = 1'b1;
        send_frame(8'hA5, 3, -1, -1);
        settle();
        chk("t4_ferr", o_frame_err, 1);
        chk("t4_count", o_count, 0);
        chk("t4_no_byte", rxq.size(), 0);
        idle(CLK_DIV);
        send_frame(8'h3C, 0, -1, -1);
        settle();
        chk("t4_next_n", rxq.size(), 1);
        chk("t4_next_data", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h3C);
        chk("t4_ferr_sticky", o_frame_err, 1);
        pulse_clr();
        #1;
        chk("t4_ferr_cleared", o_frame_err, 0);
        idle(CLK_DIV);

        // 5: short low glitch is not a start bit
        rxq.delete();
        @(negedge clk);
        i_rx = 1'b0;
        idle(CLK_DIV / 4);
        i_rx = 1'b1;
        idle(3 * CLK_DIV);
        chk("t5_no_byte", rxq.size(), 0);
        chk("t5_count", o_count, 0);
        chk("t5_ferr", o_frame_err, 0);
        send_frame(8'h96, 0, -1, -1);
        settle();
        chk("t5_after_n", rxq.size(), 1);
        chk("t5_after_data", (rxq.size() > 0) ? rxq[0] : 8'hxx, 8'h96);
        idle(CLK_DIV);

        // 6: reset during data bits of a frame, with flag and data pending
        i_ready = 1'b0;
        send_frame(8'hFF, 1, -1, -1);
        idle(CLK_DIV);
        send_frame(8'h5A, 0, -1, -1);
        chk("t6_pre_count", o_count, 1);
        chk("t6_pre_ferr", o_frame_err, 1);
        send_frame(8'hF0, 0, -1, 4 * CLK_DIV + 4);
        rxq.delete();
        i_ready = 1'b1;
        idle(CLK_DIV);
        send_frame(8'h7E, 0, -1, -1);
        settle();
        chk("t6_got_byte", rxq.size() > 0, 1);
        chk("t6_data", (rxq.size() > 0) ? rxq[$] : 8'hxx, 8'h7E);
        i_ready = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
